// File: rtl/gpr_bus_pkg.sv
// Shared constants and enumerations for the GPR bus transfer sequencer.
package gpr_bus_pkg;

  localparam int GPR_NUM_REGS = 8;
  localparam int GPR_DATA_W   = 16;
  localparam int GPR_IDX_W    = 3;

  typedef enum logic [1:0] {
    OP_MOV  = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_ZERO = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/gpr_transfer_sequencer_if.sv
// Request and GPR bus signals between decoder, sequencer and register bank.
// The carry signal exists only when GPR_XFER_CARRY_EN is defined.
interface gpr_transfer_sequencer_if #(
  parameter int NUM_REGS = gpr_bus_pkg::GPR_NUM_REGS,
  parameter int DATA_W   = gpr_bus_pkg::GPR_DATA_W
);
  import gpr_bus_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [GPR_IDX_W-1:0]    req_src;
  logic [GPR_IDX_W-1:0]    req_dst;
  logic [1:0]              req_op;
  logic [NUM_REGS-1:0]     RA;
  logic [DATA_W-1:0]       A_bus;
  logic [NUM_REGS-1:0]     SR;
  logic [DATA_W-1:0]       S_bus;
  logic                    busy;
  logic                    done;
`ifdef GPR_XFER_CARRY_EN
  logic                    carry;
`endif

  modport master (
    input  req_valid, req_src, req_dst, req_op, A_bus,
    output req_ready, RA, SR, S_bus, busy, done
`ifdef GPR_XFER_CARRY_EN
    , output carry
`endif
  );

  modport slave (
    output req_valid, req_src, req_dst, req_op, A_bus,
    input  req_ready, RA, SR, S_bus, busy, done
`ifdef GPR_XFER_CARRY_EN
    , input carry
`endif
  );

endinterface

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot select; all-zero when disabled or index out of range.
module reg_sel_decoder #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (32'(idx) < NUM_REGS)) begin
      onehot = NUM_REGS'(1) << idx;
    end
  end

endmodule

// File: rtl/gpr_transfer_sequencer.sv
// GPR register-to-register transfer initiator: A-bus read, unary op, S-bus store.
// Optional carry output enabled by defining GPR_XFER_CARRY_EN.
//
// state | meaning
// IDLE  | ready for a request; RA/SR/S_bus low
// READ  | RA selects source; A_bus result staged for the store
// WRITE | SR strobes destination with S_bus; done follows
module gpr_transfer_sequencer
  import gpr_bus_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int DATA_W   = GPR_DATA_W
) (
  input logic                      CLK,
  input logic                      CLR,
  gpr_transfer_sequencer_if.master bus
);

  state_e               state;
  op_e                  op_q;
  op_e                  req_op;
  logic [GPR_IDX_W-1:0] dst_q;
  logic [GPR_IDX_W-1:0] sr_idx;
  logic [NUM_REGS-1:0]  ra_q, sr_q, ra_hot, sr_hot;
  logic [DATA_W-1:0]    s_bus_q;
  logic                 ready_q, busy_q, done_q;
  logic                 accept;
`ifdef GPR_XFER_CARRY_EN
  logic                 carry_q;
`endif

  function automatic logic [DATA_W-1:0] apply_op(op_e op, logic [DATA_W-1:0] v);
    case (op)
      OP_MOV:  return v;
      OP_INC:  return v + DATA_W'(1);
      OP_DEC:  return v - DATA_W'(1);
      default: return '0;
    endcase
  endfunction

  assign req_op = op_e'(bus.req_op);
  assign accept = ready_q && bus.req_valid;
  // Selects are decoded one cycle ahead and registered, so the SR decoder
  // looks at the incoming request in IDLE and at the latched one in READ.
  assign sr_idx = (state == IDLE) ? bus.req_dst : dst_q;

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(GPR_IDX_W)) u_ra_dec (
    .en     (accept && (req_op != OP_ZERO)),
    .idx    (bus.req_src),
    .onehot (ra_hot)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(GPR_IDX_W)) u_sr_dec (
    .en     ((accept && (req_op == OP_ZERO)) || (state == READ)),
    .idx    (sr_idx),
    .onehot (sr_hot)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state   <= IDLE;
      op_q    <= OP_MOV;
      dst_q   <= '0;
      ra_q    <= '0;
      sr_q    <= '0;
      s_bus_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GPR_XFER_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      ra_q    <= ra_hot;
      sr_q    <= sr_hot;
      s_bus_q <= '0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dst_q   <= bus.req_dst;
            op_q    <= req_op;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= (req_op == OP_ZERO) ? WRITE : READ;
          end
        end
        READ: begin
          s_bus_q <= apply_op(op_q, bus.A_bus);
          state   <= WRITE;
        end
        WRITE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef GPR_XFER_CARRY_EN
          // Wrap is visible in the stored result: INC landed on 0, DEC on all-ones.
          carry_q <= ((op_q == OP_INC) && (s_bus_q == '0)) ||
                     ((op_q == OP_DEC) && (s_bus_q == '1));
`endif
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.RA        = ra_q;
  assign bus.SR        = sr_q;
  assign bus.S_bus     = s_bus_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef GPR_XFER_CARRY_EN
  assign bus.carry     = carry_q;
`endif

endmodule

// File: doc/gpr_transfer_sequencer.md
# gpr_transfer_sequencer

Bus-side initiator for the general-purpose register bank: accepts register-to-register transfer requests, drives the one-hot A-bus read selects (R0A..R7A), captures the A bus, applies a simple unary operation and drives the S bus with the matching one-hot store strobe (SR0..SR7). It is the controller on the opposite end of the GPR read-enable/store interface and sits between the instruction decoder and the register bank.

## Interface
Parameters:
- NUM_REGS, 8, number of GPRs addressed; select/strobe vectors are NUM_REGS wide
- DATA_W, 16, bus width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  reset, synchronous, active-low
- req_valid  in  1  transfer request present
- req_ready  out  1  sequencer can accept a request
- req_src  in  3  source register index
- req_dst  in  3  destination register index
- req_op  in  2  operation: 0 MOV, 1 INC, 2 DEC, 3 ZERO
- RA  out  NUM_REGS  one-hot A-bus read select (bit i = RiA)
- A_bus  in  DATA_W  OR-combined GPR outputs (unselected GPRs drive 0)
- SR  out  NUM_REGS  one-hot store strobe (bit i = SRi)
- S_bus  out  DATA_W  write data to GPRs
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the store cycle

## Operation
- States: IDLE, READ, WRITE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch src, dst, op; op ZERO -> WRITE, else -> READ.
- READ (1 cycle): RA=onehot(src); A_bus latched into tmp at cycle end -> WRITE.
- WRITE (1 cycle): SR=onehot(dst); S_bus = tmp (MOV), tmp+1 (INC), tmp-1 (DEC), 0 (ZERO) -> IDLE; done set for following cycle.
- Outside READ, RA=0; outside WRITE, SR=0 and S_bus=0. RA and SR never both nonzero.
- Arithmetic modulo 2^DATA_W: INC 16'hFFFF -> 16'h0000; DEC 16'h0000 -> 16'hFFFF.
- src==dst legal: read precedes write, destination receives op(old value).
- Request fields ignored while req_ready=0; requester must hold req_valid until accepted.
- Index >= NUM_REGS (when NUM_REGS<8): RA/SR all-zero for that cycle; transfer still completes, done still pulses.
- busy = (state != IDLE).

## Timing
- Reset (CLR=0 at an edge): state IDLE, tmp=0, done=0; so RA=0, SR=0, S_bus=0, busy=0, req_ready=1 from the next cycle.
- Reset mid-transfer: aborts immediately; no SR strobe issued after the reset edge; no done pulse.
- Accept at edge k: READ in cycle k+1, WRITE in k+2 (GPR captures at end of k+2), done=1 and req_ready=1 in k+3.
- ZERO: WRITE in k+1, done in k+2.
- New request accepted in the done cycle; throughput one MOV/INC/DEC per 3 cycles, one ZERO per 2.

## Configuration
- GPR_XFER_CARRY_EN defined: adds output carry (1 bit), registered, reset 0; updated at end of WRITE: 1 on INC wrap FFFF->0000 or DEC borrow 0000->FFFF, else 0 (MOV/ZERO clear it). Holds value otherwise.
- Not defined: carry port and logic absent; all else identical.

## Structure
- Shared package gpr_bus_pkg: DATA_W and NUM_REGS constants, op encoding typedef (MOV/INC/DEC/ZERO), state typedef (IDLE/READ/WRITE).
- One sub-module: reg_sel_decoder (index -> one-hot NUM_REGS vector, all-zero when disabled or out of range), instantiated for RA and SR.

## Test plan
- Reset then idle: CLR low 2 cycles -> RA=0, SR=0, S_bus=0, busy=0, done=0, req_ready=1.
- MOV R2->R5 with R2=16'h1234: RA=8'h04 at k+1, SR=8'h20 and S_bus=16'h1234 at k+2, done at k+3; R5 reads 16'h1234.
- INC R7->R7 with R7=16'hFFFF: S_bus=16'h0000, SR=8'h80; carry=1 with GPR_XFER_CARRY_EN; then DEC R0(=0)->R1 gives 16'hFFFF, carry=1.
- ZERO R3 back-to-back with MOV R1->R4 (req_valid held): ZERO done at k+2, MOV accepted same cycle, RA=8'h02 at k+3; no cycle with RA and SR both nonzero.
- CLR asserted during READ of a MOV: no SR strobe ever asserted, no done, destination unchanged, req_ready=1 next cycle.
